input_conditioner: RTL
======================

# input_conditioner

Conditions the board's raw push-buttons and slide switches into the CPU's memory-mapped register-30 input word. Per-input two-flop synchronisation, per-input counter debounce, and sticky key-press latches the CPU clears with an acknowledge pulse. Sits directly upstream of the CPU's `reg30_in` port and runs on the 25 MHz CPU clock. It replaces the raw `{8'h0, ~KEY, 2'b0, SW}` concatenation.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles an input must disagree with its debounced value before the debounced value follows it (10 ms at 25 MHz). Must be ≥ 1.
- `CNT_W`, default 18: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1: CPU clock (clk25). Only clock; all flops on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `key_n`  in  4: raw push-buttons, active-low, asynchronous to `clk`.
- `sw`  in  18: raw slide switches, asynchronous to `clk`.
- `ack`  in  1: one-cycle pulse that clears all sticky press bits (CPU write strobe decoded upstream).
- `reg30_in`  out  32: `{4'h0, key_sticky[3:0], key_level[3:0], 2'b0, sw_db[17:0]}`.
- `key_press`  out  4: one-cycle pulse per key on a debounced press edge.

## Operation
- **Synchroniser.** Each of the 22 inputs passes through two flops, `s1` then `s2`. Keys are inverted before `s1`, so internal 1 means pressed.
- **Debounce, per input `i`:** 16-bit... no; each input has its own CNT_W-bit counter `cnt[i]` and stable bit `db[i]`.
  - If `s2[i] == db[i]`: `cnt[i]` ← 0.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES-1`: `db[i]` ← `s2[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]+1`.
  - Any agreeing cycle restarts the count. Counters never wrap.
- **Outputs.** `key_level` = `db` for the 4 keys; `sw_db` = `db` for the 18 switches.
- **Press-edge detect.** `key_press[i]` is registered. It is 1 for exactly the one cycle after `key_level[i]` goes 0→1. Releases (1→0) produce no pulse.
- **Sticky bits.**
  - `key_sticky[i]` sets in the same cycle `key_press[i]` asserts.
  - `ack` clears all four sticky bits.
  - If `ack` and a press edge occur in the same cycle, set wins for that key; the other keys clear.
- **Combinational path.** `reg30_in` is a pure concatenation of registered state; there is no combinational path from inputs.

## Timing
- **Reset values** (asynchronous, immediate on `reset` high):
  - All `s1`/`s2` = 0, i.e. keys released and switches 0.
  - All `cnt` = 0, all `db` = 0.
  - `key_sticky` = 0, `key_press` = 0, `reg30_in` = 32'h0.
- **After reset release with switches up:** `sw_db` reaches its true value DEBOUNCE_CYCLES+2 cycles later. No `key_press` is generated for keys held through reset.
- **Assert latency.** A raw change held steady is first visible on `key_level`/`sw_db` after the (DEBOUNCE_CYCLES+2)-th rising edge from its first sampling edge: 2 cycles of synchroniser plus DEBOUNCE_CYCLES cycles of count.
- **Press-pulse latency.** `key_press` and the `key_sticky` set follow one cycle after `key_level`.
- **Glitch rejection.**
  - A raw pulse lasting fewer than DEBOUNCE_CYCLES cycles never changes `db`.
  - A pulse of exactly DEBOUNCE_CYCLES cycles is accepted.
- **Reset mid-count.** Asserting `reset` mid-count discards the count. Debouncing restarts from 0 after release.
- **Sticky clear.** `ack` takes effect at the next rising edge: `reg30_in[27:24]` reads 0 the following cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset state:** hold `reset` with `key_n`=4'h0, `sw`=18'h3FFFF → `reg30_in`=32'h0 and `key_press`=0 throughout reset.
- **Clean press:** `key_n[0]` 1→0 held → `reg30_in[20]`=1 after 6 edges. `key_press[0]` pulses for 1 cycle on edge 7. `reg30_in[24]`=1 from edge 7 and stays after release.
- **Glitch rejection:**
  - `sw[5]` high for 3 cycles then low → `reg30_in[5]` never changes.
  - `sw[5]` high for 4 cycles → `reg30_in[5]`=1 at edge 6, returning to 0 four cycles after the raw fall plus 2.
- **Bounce:** `key_n[2]` toggles every 2 cycles for 20 cycles, then held low → exactly one `key_press[2]` pulse, 7 edges after the final settle.
- **Ack collision:** with sticky[1]=1, pulse `ack` in the same cycle that key 3's press edge fires → after that edge sticky[1]=0 and sticky[3]=1, i.e. `reg30_in[27:24]`=4'h8.
- **Reset mid-operation:** assert `reset` 2 cycles into a `sw[17]` count, release, keep `sw[17]`=1 → `reg30_in[17]`=1 exactly 6 edges after release, not earlier.

Source files
------------

// File: rtl/input_conditioner.sv
// Board input conditioner: synchronises, debounces and latches key presses for
// the CPU's register-30 input word.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic [17:0] sw,
    input  logic        ack,
    output logic [31:0] reg30_in,
    output logic [3:0]  key_press
);

    localparam int N = 22;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bits [3:0] are keys (inverted so 1 = pressed), bits [21:4] are switches.
    logic [N-1:0] raw;
    logic [N-1:0] s1_reg;
    logic [N-1:0] s2_reg;
    logic [N-1:0] db;

    assign raw = {sw, ~key_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             db_reg;
            logic             db_next;

            always_comb begin
                cnt_next = cnt_reg;
                db_next  = db_reg;
                if (s2_reg[gi] == db_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    db_next  = s2_reg[gi];
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    db_reg  <= db_next;
                end
            end

            assign db[gi] = db_reg;
        end
    endgenerate

    logic [3:0] key_level;
    logic [3:0] level_prev_reg;
    logic [3:0] armed_reg;
    logic [3:0] sticky_reg;
    logic [3:0] press_reg;
    logic [1:0] fill_reg;
    logic [3:0] press_edge;

    assign key_level = db[3:0];

    // A key only becomes eligible for press pulses once it has been seen
    // released after the synchroniser refilled, so keys held through reset
    // never produce a pulse.
    assign press_edge = key_level & ~level_prev_reg & armed_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_prev_reg <= '0;
            armed_reg      <= '0;
            sticky_reg     <= '0;
            press_reg      <= '0;
            fill_reg       <= '0;
        end else begin
            level_prev_reg <= key_level;
            fill_reg       <= {fill_reg[0], 1'b1};
            if (fill_reg[1]) begin
                armed_reg <= armed_reg | ~s2_reg[3:0];
            end
            press_reg  <= press_edge;
            sticky_reg <= (ack ? 4'h0 : sticky_reg) | press_edge;
        end
    end

    assign reg30_in  = {4'h0, sticky_reg, key_level, 2'b00, db[21:4]};
    assign key_press = press_reg;

endmodule
